esn_st_rl1_fifo: RTL and testbench
==================================

ESN_ST_RL1_FIFO -- requirements
Module: esn_st_rl1_fifo

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, number of 32-bit entries; a power of two, minimum 4.
REQ-002 The module SHALL have parameter DATA_W, default 32, payload width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit, the clock; all logic is rising-edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit, the reset; asynchronous, active-low.
REQ-005 The module SHALL have port in_valid, input, 1 bit, Avalon-ST sink valid with readyLatency 1.
REQ-006 The module SHALL have port in_data, input, DATA_W bits, sink payload.
REQ-007 The module SHALL have port in_ready, output, 1 bit, sink ready with readyLatency 1.
REQ-008 The module SHALL have port out_valid, output, 1 bit, Avalon-ST source valid with readyLatency 0.
REQ-009 The module SHALL have port out_data, output, DATA_W bits, source payload in first-word-fall-through form.
REQ-010 The module SHALL have port out_ready, input, 1 bit, source ready.
REQ-011 The module SHALL have port overflow_clr, input, 1 bit, synchronous clear of the overflow flag.
REQ-012 The module SHALL have port fill_level, output, log2(DEPTH)+1 bits, current occupancy.
REQ-013 The module SHALL have port overflow, output, 1 bit, sticky flag for a write dropped when full.

Function
REQ-014 A write SHALL occur in any cycle where in_valid=1; in_valid needs no qualification by in_ready in the same cycle.
REQ-015 in_ready SHALL be registered as in_ready <= (count_next <= DEPTH-2), so one write landing after deassertion still has space.
REQ-016 out_valid SHALL equal (count != 0), and out_data SHALL equal mem[rd_ptr], both with zero-cycle latency from the registered state.
REQ-017 A read SHALL occur when out_valid=1 and out_ready=1; out_ready while empty has no effect.
REQ-018 Write-to-out_valid latency SHALL be 1 cycle: a word written at edge n is visible after edge n.
REQ-019 Pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH with no special case; count SHALL be log2(DEPTH)+1 bits.
REQ-020 A simultaneous read and write SHALL leave count unchanged, including at count=DEPTH; at count=0 only the write takes effect.
REQ-021 A write at count=DEPTH without a simultaneous read SHALL be dropped, leave pointers and count unchanged, and set overflow.
REQ-022 overflow SHALL stay high until overflow_clr=1; if overflow_clr and a new drop coincide, the drop wins and overflow stays 1.
REQ-023 fill_level SHALL equal the registered count.
REQ-024 Data order SHALL be strictly preserved, with no duplicates and no losses except drops under REQ-021.

Reset
REQ-025 reset_n low SHALL asynchronously set count=0, rd_ptr=0, wr_ptr=0, in_ready=0, overflow=0, out_valid=0 and fill_level=0.
REQ-026 Storage memory SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-027 in_ready SHALL rise on the first clk edge after reset_n deasserts.
REQ-028 Reset asserted mid-operation SHALL discard all contents immediately.

Configuration
REQ-029 Macro ESN_ST_FIFO_DROP_CNT_EN SHALL, when defined, add output drop_count, 16 bits, reset 0, incremented on each dropped write, saturating at 0xFFFF, and cleared by overflow_clr unless a drop occurs in the same cycle, in which case it becomes 1.
REQ-030 When ESN_ST_FIFO_DROP_CNT_EN is undefined, the drop_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Shared package esn_st_pkg SHALL hold ST_DATA_W=32, the default ST_FIFO_DEPTH=16, and the DROP_CNT_W=16 constant.
REQ-032 Storage SHALL be sub-module esn_st_fifo_ram: simple dual-port, synchronous write, asynchronous read, no reset, parameterised by DEPTH and DATA_W.

Verification (DEPTH=16)
REQ-033 Reset check: hold reset_n=0 -> in_ready=0, out_valid=0, fill_level=0; release reset_n -> in_ready=1 after the first edge.
REQ-034 Ordering check: write 0x1..0x5 with out_ready=0 -> fill_level=5, out_data=0x1; then set out_ready=1 -> 0x1..0x5 emerge in 5 consecutive cycles, then out_valid=0.
REQ-035 Fill check: stream writes with out_ready=0 -> in_ready falls when fill_level reaches 15; the in-flight write is accepted -> fill_level=16 and overflow=0.
REQ-036 Steady-state check: at fill_level=8, read and write together for 10 cycles -> fill_level stays 8 and the output sequence is continuous.
REQ-037 Overflow check: at fill_level=16, force in_valid=1 with data 0xDEADBEEF -> word dropped, overflow=1, drop_count=1 when the macro is defined; pulse overflow_clr -> overflow=0.
REQ-038 Mid-operation reset check: assert reset_n at fill_level=7 -> fill_level=0 and out_valid=0 with no clock edge required.

Source files
------------

// File: rtl/esn_st_pkg.sv
// rtl/esn_st_pkg.sv - shared constants for the streaming FIFO slice
package esn_st_pkg;

  localparam int ST_DATA_W     = 32;
  localparam int ST_FIFO_DEPTH = 16;
  localparam int DROP_CNT_W    = 16;

endpackage

// File: rtl/esn_st_fifo_ram.sv
// rtl/esn_st_fifo_ram.sv - simple dual-port storage, synchronous write, asynchronous read
module esn_st_fifo_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  // Contents are deliberately left unreset; the FIFO qualifies reads with its own count.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/esn_st_rl1_fifo.sv
// rtl/esn_st_rl1_fifo.sv - FWFT FIFO, readyLatency-1 sink, sticky overflow; optional ESN_ST_FIFO_DROP_CNT_EN adds drop_count
module esn_st_rl1_fifo
  import esn_st_pkg::*;
#(
  parameter int DEPTH  = ST_FIFO_DEPTH,
  parameter int DATA_W = ST_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  input  logic                     overflow_clr,
  output logic [$clog2(DEPTH):0]   fill_level,
`ifdef ESN_ST_FIFO_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0]    drop_count,
`endif
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          overflow_q, overflow_d;
  logic          full;
  logic          rd_en;
  logic          wr_en;
  logic          drop;

  assign full  = (count_q == CW'(DEPTH));
  assign rd_en = (count_q != '0) && out_ready;
  // in_valid is not qualified by in_ready: the sink absorbs one in-flight word after deassertion.
  assign wr_en = in_valid && (!full || rd_en);
  assign drop  = in_valid && full && !rd_en;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CW'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
    in_ready_d = (count_d <= CW'(DEPTH - 2));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef ESN_ST_FIFO_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // A drop coinciding with a clear restarts the tally at one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (overflow_clr) begin
        drop_cnt_d = DROP_CNT_W'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end else if (overflow_clr) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  esn_st_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_ptr_q),
    .rd_data (out_data)
  );

  assign in_ready   = in_ready_q;
  assign out_valid  = (count_q != '0);
  assign fill_level = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_esn_st_rl1_fifo.sv
// tb/tb_esn_st_rl1_fifo.sv - queue-model and directed checks for esn_st_rl1_fifo
module tb_esn_st_rl1_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic              overflow_clr = 1'b0;
  logic [4:0]        fill_level;
  logic              overflow;
`ifdef ESN_ST_FIFO_DROP_CNT_EN
  logic [15:0]       drop_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  esn_st_rl1_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .overflow_clr (overflow_clr),
    .fill_level   (fill_level),
`ifdef ESN_ST_FIFO_DROP_CNT_EN
    .drop_count   (drop_count),
`endif
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of accepted words plus the flags, advanced per clock from the rules.
  logic [DATA_W-1:0] mq[$];
  bit  m_rdy = 0;
  bit  m_ovf = 0;
  int  m_dc = 0;
  bit  m_rd, m_drop;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_rdy = 0;
      m_ovf = 0;
      m_dc  = 0;
    end else begin
      m_rd   = (mq.size() != 0) && out_ready;
      m_drop = in_valid && (mq.size() == DEPTH) && !m_rd;
      if (m_rd) void'(mq.pop_front());
      if (in_valid && !m_drop) mq.push_back(in_data);
      if (m_drop) begin
        m_ovf = 1;
        m_dc  = overflow_clr ? 1 : ((m_dc == 16'hFFFF) ? m_dc : m_dc + 1);
      end else if (overflow_clr) begin
        m_ovf = 0;
        m_dc  = 0;
      end
      m_rdy = (mq.size() <= DEPTH - 2);
    end
  end

  always @(negedge clk) begin
    chk("m_valid", out_valid, (mq.size() != 0));
    chk("m_fill", fill_level, mq.size());
    chk("m_ready", in_ready, m_rdy);
    chk("m_ovf", overflow, m_ovf);
    if (mq.size() != 0) chk("m_data", out_data, mq[0]);
`ifdef ESN_ST_FIFO_DROP_CNT_EN
    chk("m_dcnt", drop_count, m_dc);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] nxt;

  initial begin
    // Reset hold and release
    #12;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill_level, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("rel_ready", in_ready, 1);

    // Ordering
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      tick();
    end
    in_valid = 1'b0;
    chk("ord_fill", fill_level, 5);
    chk("ord_head", out_data, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      chk("ord_valid", out_valid, 1);
      chk("ord_data", out_data, k);
      tick();
    end
    chk("ord_empty", out_valid, 0);
    out_ready = 1'b0;

    // Fill to in_ready fall, then the in-flight word
    nxt = 32'h100;
    for (int c = 0; c < 40 && fill_level != 15; c++) begin
      in_valid = 1'b1;
      in_data  = nxt;
      nxt++;
      tick();
    end
    chk("fill_15", fill_level, 15);
    chk("fill_rdy_low", in_ready, 0);
    in_data = nxt;
    nxt++;
    tick();
    in_valid = 1'b0;
    chk("fill_16", fill_level, 16);
    chk("fill_no_ovf", overflow, 0);

    // Drop when full
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_fill", fill_level, 16);
    chk("ovf_head", out_data, 32'h100);
`ifdef ESN_ST_FIFO_DROP_CNT_EN
    chk("ovf_dcnt", drop_count, 1);
`endif
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    // Drop and clear in the same cycle: the drop wins
    in_valid = 1'b1;
    overflow_clr = 1'b1;
    in_data = 32'hBAD0BAD0;
    tick();
    in_valid = 1'b0;
    overflow_clr = 1'b0;
    chk("ovf_race", overflow, 1);
`ifdef ESN_ST_FIFO_DROP_CNT_EN
    chk("ovf_race_dcnt", drop_count, 1);
`endif
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr2", overflow, 0);

    // Read and write together while full
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = nxt;
    nxt++;
    tick();
    in_valid  = 1'b0;
    chk("full_rw_fill", fill_level, 16);
    chk("full_rw_head", out_data, 32'h101);
    chk("full_rw_ovf", overflow, 0);

    // Drain to 8, then steady state
    for (int c = 0; c < 40 && fill_level != 8; c++) tick();
    chk("ss_start", fill_level, 8);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = nxt;
      nxt++;
      tick();
      chk("ss_fill", fill_level, 8);
      chk("ss_valid", out_valid, 1);
    end
    in_valid = 1'b0;

    // Mid-operation reset at 7
    for (int c = 0; c < 40 && fill_level != 7; c++) tick();
    out_ready = 1'b0;
    chk("mr_start", fill_level, 7);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_fill", fill_level, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_ready", in_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("mr_rel_ready", in_ready, 1);
    chk("mr_rel_fill", fill_level, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
